// File: rtl/instruction_fetch_if.sv
// Bundle of the instruction-memory port and the decoder-side handshake
// seen by the fetch unit; master is the fetch unit, slave is its environment.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        busy;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  pc_load, pc_target,
    output instr_valid,
    input  instr_ready,
    output instruction, instr_pc, busy
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output pc_load, pc_target,
    input  instr_valid,
    output instr_ready,
    input  instruction, instr_pc, busy
  );
endinterface

// File: rtl/instruction_fetch.sv
// Credit-based instruction fetch: issues req/gnt fetches, tracks in-order
// responses through an address queue and buffers them for the decoder.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fentry_t;

  logic [31:0]             fetch_pc;
  fentry_t [DEPTH-1:0]     fifo;
  logic [DEPTH-1:0][31:0]  aq;
  logic [PW-1:0]           f_rd, f_wr, a_rd, a_wr;
  logic [CW-1:0]           fifo_count, outstanding, discard;
  logic [CW:0]             used;
  logic                    issue, resp, push, pop;

  // Credit counts fetches already in flight, so a full FIFO never overflows.
  assign used  = {1'b0, fifo_count} + {1'b0, outstanding};
  assign bus.imem_req  = (used < (CW+1)'(DEPTH)) & ~bus.pc_load & ~reset;
  assign bus.imem_addr = fetch_pc;

  assign issue = bus.imem_req & bus.imem_gnt;
  assign resp  = bus.imem_rvalid & (outstanding != '0);
  assign push  = resp & ~bus.pc_load & (discard == '0);
  assign pop   = bus.instr_valid & bus.instr_ready;

  assign bus.instr_valid = (fifo_count != '0) & ~bus.pc_load;
  assign bus.instruction = fifo[f_rd].data;
  assign bus.instr_pc    = fifo[f_rd].pc;
  assign bus.busy        = (outstanding != '0) | (discard != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      fifo        <= '0;
      aq          <= '0;
      f_rd        <= '0;
      f_wr        <= '0;
      a_rd        <= '0;
      a_wr        <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (issue) begin
        aq[a_wr] <= fetch_pc;
        a_wr     <= a_wr + PW'(1);
      end
      if (resp) a_rd <= a_rd + PW'(1);
      outstanding <= outstanding + CW'(issue) - CW'(resp);

      // Address queue is left alone on redirect: stale entries retire with
      // their dropped responses, keeping outstanding exact.
      if (bus.pc_load) begin
        fetch_pc   <= {bus.pc_target[31:2], 2'b00};
        f_rd       <= '0;
        f_wr       <= '0;
        fifo_count <= '0;
        discard    <= outstanding - CW'(resp);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          fifo[f_wr] <= {aq[a_rd], bus.imem_rdata};
          f_wr       <= f_wr + PW'(1);
        end
        if (pop) f_rd <= f_rd + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (resp && discard != '0) discard <= discard - CW'(1);
      end
    end
  end
endmodule
